// File: rtl/crc_err_frame_filter.sv
// Store-and-forward frame buffer that sits behind the CRC check stage.
// A frame becomes visible to the read side only after it ends with a good CRC. Bad,
// truncated or overflowed frames are dropped by rewinding the write pointer to the
// last commit point. Committed frames are replayed with sop/eop/vld/ready framing.
// Optional build macro ERR_CNT_EN adds saturating drop/overflow/commit counters.
module crc_err_frame_filter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DESC_W = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iSop,
    input  logic              iVld,
    input  logic [DATA_W-1:0] iData,
    input  logic              iEop,
    input  logic              iErr,
    output logic              oReady,
    output logic              oSop,
    output logic              oEop,
    output logic              oVld,
    output logic [DATA_W-1:0] oData,
    input  logic              iReady
`ifdef ERR_CNT_EN
    ,
    output logic [15:0]       oDropCnt,
    output logic [15:0]       oOvfCnt,
    output logic [15:0]       oFrmCnt
`endif
);

    localparam int unsigned      DEPTH    = 1 << ADDR_W;
    localparam int unsigned      DDEPTH   = 1 << DESC_W;
    localparam logic [ADDR_W:0]  FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]  CNT_TWO  = (ADDR_W + 1)'(2);

    typedef enum logic [1:0] {WIdle, WFrame, WDrop} wState_e;
    typedef enum logic [1:0] {RIdle, RLoad, RSend} rState_e;

    // Write side
    wState_e           wStateQ, wStateD;
    logic [ADDR_W:0]   wrPtrQ, wrPtrD;
    logic [ADDR_W:0]   commitPtrQ, commitPtrD;
    logic [ADDR_W:0]   wcntQ, wcntD;
    logic [ADDR_W:0]   basePtr;
    logic              startReq;
    logic              sopWord;
    logic              memWe;
    logic [ADDR_W-1:0] memWaddr;

    // Descriptor FIFO (frame word counts)
    logic [ADDR_W:0]   descMem [DDEPTH];
    logic [DESC_W:0]   descWpQ, descRpQ;
    logic              descPush, descPop;
    logic              descEmpty, descFull;
    logic [ADDR_W:0]   descHead;

    // Read side
    rState_e           rStateQ, rStateD;
    logic [ADDR_W:0]   rdPtrQ, rdPtrD;
    logic [ADDR_W:0]   rcntQ, rcntD;
    logic              memRe;
    logic [ADDR_W-1:0] memRaddr;
    logic [DATA_W-1:0] ramQ;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              vldD, sopD, eopD;
    logic [DATA_W-1:0] dataD;

    assign sopWord   = iSop & iVld;
    assign descEmpty = (descWpQ == descRpQ);
    assign descFull  = (descWpQ[DESC_W] != descRpQ[DESC_W]) &&
                       (descWpQ[DESC_W-1:0] == descRpQ[DESC_W-1:0]);
    assign descHead  = descMem[descRpQ[DESC_W-1:0]];
    // Uncommitted words count as used, so space is measured against the write pointer
    assign oReady    = ((wrPtrQ - rdPtrQ) != FULL_LVL) && !descFull;

    // Write FSM: accept words, commit on good eop, rewind to commitPtr on any drop
    always_comb begin
        wStateD    = wStateQ;
        wrPtrD     = wrPtrQ;
        commitPtrD = commitPtrQ;
        wcntD      = wcntQ;
        memWe      = 1'b0;
        memWaddr   = wrPtrQ[ADDR_W-1:0];
        descPush   = 1'b0;
        basePtr    = wrPtrQ;
        startReq   = 1'b0;
        unique case (wStateQ)
            WIdle: begin
                startReq = sopWord;
            end
            WFrame: begin
                if (iEop) begin
                    if (!iErr && (wcntQ != '0) && !descFull) begin
                        descPush   = 1'b1;
                        commitPtrD = wrPtrQ;
                    end else begin
                        wrPtrD  = commitPtrQ;
                        basePtr = commitPtrQ;
                    end
                    wStateD  = WIdle;
                    // A coincident new sop lands at the pointer left by this frame
                    startReq = sopWord;
                end else if (sopWord) begin
                    // Missing eop: discard the partial frame and restart
                    wrPtrD   = commitPtrQ;
                    basePtr  = commitPtrQ;
                    startReq = 1'b1;
                end else if (iVld) begin
                    if (oReady) begin
                        memWe  = 1'b1;
                        wrPtrD = wrPtrQ + CNT_ONE;
                        wcntD  = wcntQ + CNT_ONE;
                    end else begin
                        wStateD = WDrop;
                    end
                end
            end
            WDrop: begin
                if (iEop || sopWord) begin
                    wrPtrD   = commitPtrQ;
                    basePtr  = commitPtrQ;
                    wStateD  = WIdle;
                    startReq = sopWord;
                end
            end
            default: wStateD = WIdle;
        endcase
        if (startReq) begin
            if (((basePtr - rdPtrQ) != FULL_LVL) && !descFull) begin
                memWe    = 1'b1;
                memWaddr = basePtr[ADDR_W-1:0];
                wrPtrD   = basePtr + CNT_ONE;
                wcntD    = CNT_ONE;
                wStateD  = WFrame;
            end else begin
                wrPtrD  = basePtr;
                wStateD = WDrop;
            end
        end
    end

    // Read FSM: pop a descriptor, prime the RAM pipeline, stream words with a prefetch
    always_comb begin
        rStateD  = rStateQ;
        rdPtrD   = rdPtrQ;
        rcntD    = rcntQ;
        descPop  = 1'b0;
        memRe    = 1'b0;
        memRaddr = rdPtrQ[ADDR_W-1:0];
        vldD     = oVld;
        sopD     = oSop;
        eopD     = oEop;
        dataD    = oData;
        unique case (rStateQ)
            RIdle: begin
                if (!descEmpty) begin
                    descPop = 1'b1;
                    rcntD   = descHead;
                    memRe   = 1'b1;
                    rStateD = RLoad;
                end
            end
            RLoad: begin
                vldD     = 1'b1;
                sopD     = 1'b1;
                eopD     = (rcntQ == CNT_ONE);
                dataD    = ramQ;
                memRe    = 1'b1;
                memRaddr = rdPtrQ[ADDR_W-1:0] + ADDR_W'(1);
                rStateD  = RSend;
            end
            RSend: begin
                if (oVld && iReady) begin
                    // rdPtr tracks the word on the output, so space frees only on transfer
                    rdPtrD = rdPtrQ + CNT_ONE;
                    if (oEop) begin
                        vldD    = 1'b0;
                        sopD    = 1'b0;
                        eopD    = 1'b0;
                        rStateD = RIdle;
                    end else begin
                        sopD     = 1'b0;
                        dataD    = ramQ;
                        rcntD    = rcntQ - CNT_ONE;
                        eopD     = (rcntQ == CNT_TWO);
                        memRe    = 1'b1;
                        memRaddr = rdPtrQ[ADDR_W-1:0] + ADDR_W'(2);
                    end
                end
            end
            default: rStateD = RIdle;
        endcase
    end

    // Data RAM: one write port, one synchronous read port
    always_ff @(posedge iClk) begin
        if (memWe) begin
            mem[memWaddr] <= iData;
        end
        if (memRe) begin
            ramQ <= mem[memRaddr];
        end
    end

    // Descriptor storage
    always_ff @(posedge iClk) begin
        if (descPush) begin
            descMem[descWpQ[DESC_W-1:0]] <= wcntQ;
        end
    end

    // State, pointers and output register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wStateQ    <= WIdle;
            wrPtrQ     <= '0;
            commitPtrQ <= '0;
            wcntQ      <= '0;
            descWpQ    <= '0;
            descRpQ    <= '0;
            rStateQ    <= RIdle;
            rdPtrQ     <= '0;
            rcntQ      <= '0;
            oVld       <= 1'b0;
            oSop       <= 1'b0;
            oEop       <= 1'b0;
            oData      <= '0;
        end else begin
            wStateQ    <= wStateD;
            wrPtrQ     <= wrPtrD;
            commitPtrQ <= commitPtrD;
            wcntQ      <= wcntD;
            if (descPush) begin
                descWpQ <= descWpQ + 1'b1;
            end
            if (descPop) begin
                descRpQ <= descRpQ + 1'b1;
            end
            rStateQ    <= rStateD;
            rdPtrQ     <= rdPtrD;
            rcntQ      <= rcntD;
            oVld       <= vldD;
            oSop       <= sopD;
            oEop       <= eopD;
            oData      <= dataD;
        end
    end

`ifdef ERR_CNT_EN
    logic crcDrop, ovfDrop;

    // Classify frame endings; an eop with no frame open is a zero-length CRC drop
    always_comb begin
        crcDrop = iEop && ((wStateQ == WIdle) || ((wStateQ == WFrame) && iErr));
        ovfDrop = ((wStateQ != WDrop) && (wStateD == WDrop)) ||
                  ((wStateQ == WFrame) && !iEop && sopWord) ||
                  ((wStateQ == WFrame) && iEop && !iErr && !descPush);
    end

    // Saturating statistics counters
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oDropCnt <= '0;
            oOvfCnt  <= '0;
            oFrmCnt  <= '0;
        end else begin
            if (crcDrop && (oDropCnt != 16'hFFFF)) begin
                oDropCnt <= oDropCnt + 16'd1;
            end
            if (ovfDrop && (oOvfCnt != 16'hFFFF)) begin
                oOvfCnt <= oOvfCnt + 16'd1;
            end
            if (descPush && (oFrmCnt != 16'hFFFF)) begin
                oFrmCnt <= oFrmCnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_crc_err_frame_filter.sv
// Directed bench for crc_err_frame_filter built with a 16-word data RAM.
// Output transfers are captured into a queue and compared against hand-built frames.
module tb_crc_err_frame_filter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DESC_W = 4;

    logic              iClk = 1'b0;
    logic              iRst;
    logic              iSop, iVld, iEop, iErr, iReady;
    logic [DATA_W-1:0] iData;
    logic              oReady, oSop, oEop, oVld;
    logic [DATA_W-1:0] oData;
`ifdef ERR_CNT_EN
    logic [15:0]       dropCnt, ovfCnt, frmCnt;
`endif

    int errCnt = 0;
    int chkCnt = 0;
    logic [33:0] capQ[$];
    logic [33:0] expQ[$];

    always #5 iClk = ~iClk;

    crc_err_frame_filter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DESC_W(DESC_W)
    ) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iSop    (iSop),
        .iVld    (iVld),
        .iData   (iData),
        .iEop    (iEop),
        .iErr    (iErr),
        .oReady  (oReady),
        .oSop    (oSop),
        .oEop    (oEop),
        .oVld    (oVld),
        .oData   (oData),
        .iReady  (iReady)
`ifdef ERR_CNT_EN
        ,
        .oDropCnt(dropCnt),
        .oOvfCnt (ovfCnt),
        .oFrmCnt (frmCnt)
`endif
    );

    // Record every accepted output word
    always @(negedge iClk) begin
        if (!iRst && oVld && iReady) begin
            capQ.push_back({oSop, oEop, oData});
        end
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic sop, input logic vld, input logic [31:0] data,
                         input logic eop, input logic err);
        iSop  = sop;
        iVld  = vld;
        iData = data;
        iEop  = eop;
        iErr  = err;
        @(posedge iClk);
        #1;
        iSop  = 1'b0;
        iVld  = 1'b0;
        iData = '0;
        iEop  = 1'b0;
        iErr  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic sendFrame(input int n, input logic [31:0] base, input logic err);
        for (int i = 0; i < n; i++) begin
            drive((i == 0), 1'b1, base + 32'(i), 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, err);
    endtask

    task automatic expFrame(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            expQ.push_back({(i == 0), (i == n - 1), base + 32'(i)});
        end
    endtask

    task automatic doReset();
        iRst   = 1'b1;
        iSop   = 1'b0;
        iVld   = 1'b0;
        iData  = '0;
        iEop   = 1'b0;
        iErr   = 1'b0;
        iReady = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        capQ.delete();
        expQ.delete();
        idle(1);
    endtask

    task automatic drainCheck(input string tag, input int budget);
        int n = 0;
        while ((capQ.size() < expQ.size()) && (n < budget)) begin
            @(posedge iClk);
            #1;
            n++;
        end
        idle(10);
        checkEq({tag, "_count"}, 64'(capQ.size()), 64'(expQ.size()));
        for (int i = 0; (i < expQ.size()) && (i < capQ.size()); i++) begin
            checkEq($sformatf("%s_w%0d", tag, i), 64'(capQ[i]), 64'(expQ[i]));
        end
    endtask

`ifdef ERR_CNT_EN
    task automatic checkCnt(input string tag, input int d, input int o, input int f);
        checkEq({tag, "_dropcnt"}, 64'(dropCnt), 64'(d));
        checkEq({tag, "_ovfcnt"}, 64'(ovfCnt), 64'(o));
        checkEq({tag, "_frmcnt"}, 64'(frmCnt), 64'(f));
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errCnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [3:0] pat;

        // Reset values
        iRst   = 1'b1;
        iSop   = 1'b0;
        iVld   = 1'b0;
        iData  = '0;
        iEop   = 1'b0;
        iErr   = 1'b0;
        iReady = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        checkEq("rst_vld", 64'(oVld), 64'd0);
        checkEq("rst_sop", 64'(oSop), 64'd0);
        checkEq("rst_eop", 64'(oEop), 64'd0);
        checkEq("rst_data", 64'(oData), 64'd0);
        checkEq("rst_ready", 64'(oReady), 64'd1);

        // Good 4-word frame: 3-cycle latency, no gaps
        doReset();
        sendFrame(4, 32'hA0, 1'b0);
        n = 0;
        do begin
            @(negedge iClk);
            n++;
        end while (!oVld && (n < 20));
        checkEq("t1_latency", 64'(n), 64'd3);
        for (int i = 0; i < 4; i++) begin
            checkEq($sformatf("t1_w%0d", i), 64'({oVld, oSop, oEop, oData}),
                    64'({1'b1, (i == 0), (i == 3), 32'hA0 + 32'(i)}));
            @(negedge iClk);
        end
        checkEq("t1_end_vld", 64'(oVld), 64'd0);

        // CRC-error frame dropped, following good frame passes
        doReset();
        sendFrame(6, 32'hC0, 1'b1);
        sendFrame(2, 32'hB0, 1'b0);
        expFrame(2, 32'hB0);
        drainCheck("t2", 50);
`ifdef ERR_CNT_EN
        checkCnt("t2", 1, 0, 1);
`endif

        // Overflow: 20 words into 16 with output blocked
        doReset();
        iReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive((i == 0), 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            if (i == 14) checkEq("t3_ready_at15", 64'(oReady), 64'd1);
            if (i == 15) checkEq("t3_ready_at16", 64'(oReady), 64'd0);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkEq("t3_ready_rewind", 64'(oReady), 64'd1);
        idle(5);
        checkEq("t3_no_out", 64'(oVld), 64'd0);
        iReady = 1'b1;
        sendFrame(3, 32'h30, 1'b0);
        expFrame(3, 32'h30);
        drainCheck("t3", 50);
`ifdef ERR_CNT_EN
        checkCnt("t3", 0, 1, 1);
`endif

        // Backpressure 1,0,0,1 during an 8-word frame
        doReset();
        sendFrame(8, 32'hD0, 1'b0);
        expFrame(8, 32'hD0);
        pat = 4'b1001;
        for (int k = 0; k < 40; k++) begin
            if (oVld && (capQ.size() < expQ.size())) begin
                checkEq($sformatf("t4_present%0d", k), 64'({oSop, oEop, oData}),
                        64'(expQ[capQ.size()]));
            end
            iReady = pat[k % 4];
            @(posedge iClk);
            #1;
        end
        iReady = 1'b1;
        drainCheck("t4", 50);

        // Truncated frame rewound; space proven by filling exactly to 16
        doReset();
        iReady = 1'b0;
        drive(1'b1, 1'b1, 32'hE0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'hE1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'hE2, 1'b0, 1'b0);
        sendFrame(2, 32'hF0, 1'b0);
        expFrame(2, 32'hF0);
        for (int i = 0; i < 14; i++) begin
            drive((i == 0), 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
            if (i == 12) checkEq("t5_ready_at15", 64'(oReady), 64'd1);
            if (i == 13) checkEq("t5_ready_at16", 64'(oReady), 64'd0);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        expFrame(14, 32'h200);
        iReady = 1'b1;
        drainCheck("t5", 100);
`ifdef ERR_CNT_EN
        checkCnt("t5", 0, 1, 2);
`endif

        // Ten 5-word frames wrap the 16-word RAM several times
        doReset();
        for (int f = 0; f < 10; f++) begin
            sendFrame(5, 32'h600 + 32'(16 * f), 1'b0);
            expFrame(5, 32'h600 + 32'(16 * f));
            idle(4);
        end
        drainCheck("t6", 100);

        // Reset in the middle of both a stalled output frame and an input frame
        capQ.delete();
        expQ.delete();
        iReady = 1'b0;
        sendFrame(3, 32'h700, 1'b0);
        idle(5);
        drive(1'b1, 1'b1, 32'h710, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h711, 1'b0, 1'b0);
        checkEq("t6_vld_before_rst", 64'(oVld), 64'd1);
        iRst = 1'b1;
        @(negedge iClk);
        checkEq("t6_rst_vld", 64'(oVld), 64'd0);
        checkEq("t6_rst_ready", 64'(oReady), 64'd1);
        @(negedge iClk);
        iRst   = 1'b0;
        iReady = 1'b1;
        drive(1'b0, 1'b1, 32'h712, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(10);
        checkEq("t6_no_partial", 64'(capQ.size()), 64'd0);
        sendFrame(2, 32'h720, 1'b0);
        expFrame(2, 32'h720);
        drainCheck("t6_post", 50);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
